// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8-bit UART receiver (start, 8 data MSB-first, parity, stop).
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around the mid-bit sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int BIT_DURATION = 27,
  parameter int SAMPLE_POINT = 13
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity,
  output logic       rx_complete,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam logic [4:0] BIT_LAST = 5'(BIT_DURATION - 1);

  // clk_cnt is zero on the cycle after the start edge, so cycle T0+m holds m-1.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [4:0] DECIDE_CNT = 5'(SAMPLE_POINT);
`else
  localparam logic [4:0] DECIDE_CNT = 5'(SAMPLE_POINT - 1);
`endif

  state_t     state_q, state_d;
  logic [4:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_bit_q, par_bit_d;
  logic [1:0] sync_q, sync_d;
  logic [7:0] rx_msg_q, rx_msg_d;
  logic       rx_parity_q, rx_parity_d;
  logic       rx_complete_q, rx_complete_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;

  logic       rx_s;
  logic       bit_val;
  logic       is_sample;
  logic [4:0] clk_cnt_next;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
`endif

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], rx};
`ifdef UART_RX_MAJORITY_EN
    hist_d  = {hist_q[0], rx_s};
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    bit_val = rx_s;
`endif
    is_sample    = (clk_cnt_q == DECIDE_CNT);
    clk_cnt_next = (clk_cnt_q == BIT_LAST) ? 5'd0 : clk_cnt_q + 5'd1;

    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    rx_msg_d      = rx_msg_q;
    rx_parity_d   = rx_parity_q;
    rx_complete_d = 1'b0;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;

    case (state_q)
      IDLE: begin
        clk_cnt_d = 5'd0;
        bit_cnt_d = 3'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        clk_cnt_d = clk_cnt_next;
        if (is_sample) begin
          if (bit_val) begin
            state_d   = IDLE;
            clk_cnt_d = 5'd0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt_next;
        if (is_sample) begin
          shift_d   = {shift_q[6:0], bit_val};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        clk_cnt_d = clk_cnt_next;
        if (is_sample) begin
          par_bit_d = bit_val;
          state_d   = STOP;
        end
      end
      STOP: begin
        clk_cnt_d = clk_cnt_next;
        if (is_sample) begin
          // Leave right at mid-stop so a closely following start edge is caught.
          rx_msg_d      = shift_q;
          rx_parity_d   = par_bit_q;
          parity_err_d  = par_bit_q ^ ((^shift_q) ^ parity_type);
          frame_err_d   = ~bit_val;
          rx_complete_d = 1'b1;
          clk_cnt_d     = 5'd0;
          state_d       = bit_val ? IDLE : BREAK;
        end
      end
      BREAK: begin
        clk_cnt_d = 5'd0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = 5'd0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_q       <= IDLE;
      clk_cnt_q     <= 5'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      par_bit_q     <= 1'b0;
      sync_q        <= 2'b11;
      rx_msg_q      <= 8'd0;
      rx_parity_q   <= 1'b0;
      rx_complete_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q        <= 2'b11;
`endif
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      sync_q        <= sync_d;
      rx_msg_q      <= rx_msg_d;
      rx_parity_q   <= rx_parity_d;
      rx_complete_q <= rx_complete_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q        <= hist_d;
`endif
    end
  end

  assign rx_msg      = rx_msg_q;
  assign rx_parity   = rx_parity_q;
  assign rx_complete = rx_complete_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int BIT = 27;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 287;
`else
  localparam int LAT = 286;
`endif

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_type = 1'b0;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;
  logic       frame_err;

  uart_rx #(.BIT_DURATION(27), .SAMPLE_POINT(13)) dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .rx          (rx),
    .parity_type (parity_type),
    .rx_msg      (rx_msg),
    .rx_parity   (rx_parity),
    .rx_complete (rx_complete),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  always #160 clk_3125 = ~clk_3125;

  int cyc = 0;
  always @(posedge clk_3125) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail = 0;
  int         pulses = 0;
  int         exp_pulses = 0;
  int         last_cyc = 0;
  int         dbl = 0;
  int         fall_cyc = 0;
  logic       prev_c = 1'b0;
  logic [7:0] cap_msg = 8'd0;
  logic       cap_par = 1'b0;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;

  always @(negedge clk_3125) begin
    if (rx_complete) begin
      pulses   = pulses + 1;
      last_cyc = cyc;
      cap_msg  = rx_msg;
      cap_par  = rx_parity;
      cap_perr = parity_err;
      cap_ferr = frame_err;
      if (prev_c) dbl = dbl + 1;
    end
    prev_c = rx_complete;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_3125);
    #1;
  endtask

  // Called at posedge+1; drives one full frame clock by clock.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int stop_len, input int glitch_off, input int rst_off);
    logic [9:0] seq;
    logic       b;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[4'(i + 1)] = data[3'(7 - i)];
    seq[9] = par;
    fall_cyc = cyc;
    for (int c = 0; c < 10 * BIT + stop_len; c++) begin
      b   = (c < 10 * BIT) ? seq[4'(c / BIT)] : stop;
      rx  = (c == glitch_off) ? ~b : b;
      rst = (c == rst_off);
      @(posedge clk_3125);
      #1;
    end
    rx  = 1'b1;
    rst = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int msg, input int par,
                             input int perr, input int ferr);
    exp_pulses++;
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_lat"}, last_cyc, fall_cyc + LAT);
    check({tag, "_msg"}, 32'(cap_msg), msg);
    check({tag, "_par"}, 32'(cap_par), par);
    check({tag, "_perr"}, 32'(cap_perr), perr);
    check({tag, "_ferr"}, 32'(cap_ferr), ferr);
  endtask

  initial begin
    repeat (3) @(posedge clk_3125);
    #1;
    check("rst_msg", 32'(rx_msg), 0);
    check("rst_par", 32'(rx_parity), 0);
    check("rst_cmp", 32'(rx_complete), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ferr", 32'(frame_err), 0);
    rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b0, 1'b1, 27, -1, -1);
    check_frame("a5", 'hA5, 0, 0, 0);
    idle(5);

    parity_type = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 27, -1, -1);
    check_frame("3c", 'h3C, 1, 0, 0);
    parity_type = 1'b0;
    send_frame(8'h81, 1'b0, 1'b1, 27, -1, -1);
    check_frame("81", 'h81, 0, 0, 0);
    idle(5);

    send_frame(8'h81, 1'b1, 1'b1, 27, -1, -1);
    check_frame("81bad", 'h81, 1, 1, 0);
    idle(5);

    send_frame(8'h55, 1'b0, 1'b0, 127, -1, -1);
    check_frame("brk", 'h55, 0, 0, 1);
    idle(60);
    check("brk_no_extra", pulses, exp_pulses);
    send_frame(8'h0F, 1'b0, 1'b1, 27, -1, -1);
    check_frame("0f", 'h0F, 0, 0, 0);
    idle(5);

    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(400);
    check("glitch_pulses", pulses, exp_pulses);
    check("glitch_msg", 32'(rx_msg), 'h0F);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, 1'b0, 1'b1, 27, 94, -1);
    check_frame("vote", 'h00, 0, 0, 0);
    idle(5);
`endif

    parity_type = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b1, 27, -1, 148);
    idle(20);
    check("mid_rst_pulses", pulses, exp_pulses);
    check("mid_rst_msg", 32'(rx_msg), 0);
    check("mid_rst_par", 32'(rx_parity), 0);
    check("mid_rst_perr", 32'(parity_err), 0);
    check("mid_rst_ferr", 32'(frame_err), 0);
    parity_type = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1, 27, -1, -1);
    check_frame("c3", 'hC3, 0, 0, 0);
    idle(5);

    check("no_back_to_back", dbl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
